// File: rtl/rv64_ctrl_pkg.sv
// rv64_ctrl_pkg
// Shared definitions for the RV64I multicycle control slice. It holds the FSM
// state encoding, the supported opcodes and the opcode classes derived from
// them. It also holds the alu_ctrl and alu_src_b encodings, plus the packed
// bundle of control strobes that the FSM drives toward the datapath.
package rv64_ctrl_pkg;

   // FETCH must encode as zero because the debug state output reads 0 in reset
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_EXEC_I = 4'd3,
      S_ADDR   = 4'd4,
      S_MEM_RD = 4'd5,
      S_MEM_WR = 4'd6,
      S_WB_ALU = 4'd7,
      S_WB_MEM = 4'd8,
      S_BRANCH = 4'd9,
      S_TRAP   = 4'd10
   } state_t;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_R    = 3'd1,
      CLS_I    = 3'd2,
      CLS_LD   = 3'd3,
      CLS_ST   = 3'd4,
      CLS_BR   = 3'd5
   } opClass_t;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   localparam logic [1:0] SRCB_REG  = 2'd0;
   localparam logic [1:0] SRCB_FOUR = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;

   typedef struct packed {
      logic       memRead;
      logic       memWrite;
      logic       iOrD;
      logic       irWrite;
      logic       pcWrite;
      logic       pcSrc;
      logic       regWrite;
      logic       memToReg;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [3:0] aluCtrl;
      logic       retire;
      logic       illegal;
   } ctrlOut_t;

   // Unknown opcodes fall into CLS_NONE, which the decoder flags as illegal
   function automatic opClass_t classify(input logic [6:0] op);
      opClass_t cls;
      case (op)
         OP_R:    cls = CLS_R;
         OP_I:    cls = CLS_I;
         OP_LD:   cls = CLS_LD;
         OP_ST:   cls = CLS_ST;
         OP_BR:   cls = CLS_BR;
         default: cls = CLS_NONE;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/rv64_multicycle_control_alu_control_decoder.sv
// alu_control_decoder
// Combinational map from opcode class, funct3 and funct7 to the ALU operation.
// It also reports whether the funct fields form a supported encoding.
//   i_opClass  opcode class of the instruction register
//   i_funct3   instruction[14:12]
//   i_funct7   instruction[31:25]
//   o_aluCtrl  ALU operation; used by the FSM in EXEC_R / EXEC_I
//   o_illegal  1 when the opcode/funct combination is unsupported
module alu_control_decoder
   import rv64_ctrl_pkg::*;
(
   input  opClass_t   i_opClass,
   input  logic [2:0] i_funct3,
   input  logic [6:0] i_funct7,
   output logic [3:0] o_aluCtrl,
   output logic       o_illegal
);

   // For I-type, funct7 is immediate bits and is deliberately not inspected
   always_comb begin
      o_aluCtrl = ALU_ADD;
      o_illegal = 1'b0;
      case (i_opClass)
         CLS_R: begin
            if (i_funct7 == 7'b0000000) begin
               case (i_funct3)
                  3'b000:  o_aluCtrl = ALU_ADD;
                  3'b110:  o_aluCtrl = ALU_OR;
                  3'b111:  o_aluCtrl = ALU_AND;
                  default: o_illegal = 1'b1;
               endcase
            end else if (i_funct7 == 7'b0100000 && i_funct3 == 3'b000) begin
               o_aluCtrl = ALU_SUB;
            end else begin
               o_illegal = 1'b1;
            end
         end
         CLS_I: begin
            case (i_funct3)
               3'b000:  o_aluCtrl = ALU_ADD;
               3'b110:  o_aluCtrl = ALU_OR;
               3'b111:  o_aluCtrl = ALU_AND;
               default: o_illegal = 1'b1;
            endcase
         end
         CLS_LD, CLS_ST: o_illegal = (i_funct3 != 3'b011);
         CLS_BR:         o_illegal = (i_funct3 != 3'b000);
         default:        o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/rv64_multicycle_control.sv
// rv64_multicycle_control
// Control FSM that sequences a shared RV64I datapath one instruction at a time.
// Inputs : clk, reset (async, active-high), opcode/funct3/funct7 from the IR,
//          zero (ALU result == 0), mem_ready (memory completes this cycle).
// Outputs: memory request (mem_read, mem_write, i_or_d) and the IR/PC strobes
//          (ir_write, pc_write, pc_src). It also drives the register-file strobes
//          (reg_write, mem_to_reg), the ALU mux selects and alu_ctrl, plus
//          retire, a sticky illegal trap flag and the debug state output.
module rv64_multicycle_control
   import rv64_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [3:0] alu_ctrl,
   output logic       retire,
   output logic       illegal,
   output logic [3:0] state
);

   state_t   r_state;
   state_t   w_nextState;
   opClass_t w_opClass;
   logic [3:0] w_decAluCtrl;
   logic     w_decIllegal;
   ctrlOut_t w_ctrl;
   ctrlOut_t w_out;

   assign w_opClass = classify(opcode);

   alu_control_decoder u_aluDec (
      .i_opClass (w_opClass),
      .i_funct3  (funct3),
      .i_funct7  (funct7),
      .o_aluCtrl (w_decAluCtrl),
      .o_illegal (w_decIllegal)
   );

   // State register; reset aborts any instruction in flight and restarts at FETCH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_nextState;
   end

   // Next-state logic; memory states wait on mem_ready, and TRAP is absorbing
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_FETCH:  if (mem_ready) w_nextState = S_DECODE;
         S_DECODE: begin
            if (w_decIllegal) begin
               w_nextState = S_TRAP;
            end else begin
               case (w_opClass)
                  CLS_R:          w_nextState = S_EXEC_R;
                  CLS_I:          w_nextState = S_EXEC_I;
                  CLS_LD, CLS_ST: w_nextState = S_ADDR;
                  CLS_BR:         w_nextState = S_BRANCH;
                  default:        w_nextState = S_TRAP;
               endcase
            end
         end
         S_EXEC_R, S_EXEC_I: w_nextState = S_WB_ALU;
         S_ADDR:   w_nextState = (w_opClass == CLS_LD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: if (mem_ready) w_nextState = S_WB_MEM;
         S_MEM_WR: if (mem_ready) w_nextState = S_FETCH;
         S_WB_ALU, S_WB_MEM, S_BRANCH: w_nextState = S_FETCH;
         S_TRAP:   w_nextState = S_TRAP;
         default:  w_nextState = S_TRAP;
      endcase
   end

   // Output decode: Moore per state, except ir_write/pc_write/retire which are
   // gated by mem_ready or zero in the same cycle
   always_comb begin
      w_ctrl = '0;
      case (r_state)
         S_FETCH: begin
            w_ctrl.memRead = 1'b1;
            w_ctrl.aluSrcB = SRCB_FOUR;
            w_ctrl.aluCtrl = ALU_ADD;
            w_ctrl.irWrite = mem_ready;
            w_ctrl.pcWrite = mem_ready;
         end
         S_DECODE: begin
            w_ctrl.aluSrcB = SRCB_IMM;
            w_ctrl.aluCtrl = ALU_ADD;
         end
         S_EXEC_R: begin
            w_ctrl.aluSrcA = 1'b1;
            w_ctrl.aluSrcB = SRCB_REG;
            w_ctrl.aluCtrl = w_decAluCtrl;
         end
         S_EXEC_I: begin
            w_ctrl.aluSrcA = 1'b1;
            w_ctrl.aluSrcB = SRCB_IMM;
            w_ctrl.aluCtrl = w_decAluCtrl;
         end
         S_ADDR: begin
            w_ctrl.aluSrcA = 1'b1;
            w_ctrl.aluSrcB = SRCB_IMM;
            w_ctrl.aluCtrl = ALU_ADD;
         end
         S_MEM_RD: begin
            w_ctrl.memRead = 1'b1;
            w_ctrl.iOrD    = 1'b1;
         end
         S_MEM_WR: begin
            w_ctrl.memWrite = 1'b1;
            w_ctrl.iOrD     = 1'b1;
            w_ctrl.retire   = mem_ready;
         end
         S_WB_ALU: begin
            w_ctrl.regWrite = 1'b1;
            w_ctrl.retire   = 1'b1;
         end
         S_WB_MEM: begin
            w_ctrl.regWrite = 1'b1;
            w_ctrl.memToReg = 1'b1;
            w_ctrl.retire   = 1'b1;
         end
         S_BRANCH: begin
            w_ctrl.aluSrcA = 1'b1;
            w_ctrl.aluSrcB = SRCB_REG;
            w_ctrl.aluCtrl = ALU_SUB;
            w_ctrl.pcSrc   = 1'b1;
            w_ctrl.pcWrite = zero;
            w_ctrl.retire  = 1'b1;
         end
         S_TRAP:  w_ctrl.illegal = 1'b1;
         default: w_ctrl = '0;
      endcase
   end

   // Reset masks every strobe combinationally so that a request in flight
   // (e.g. mem_write) drops the moment reset rises, not at the next edge
   assign w_out = reset ? '0 : w_ctrl;

   assign mem_read   = w_out.memRead;
   assign mem_write  = w_out.memWrite;
   assign i_or_d     = w_out.iOrD;
   assign ir_write   = w_out.irWrite;
   assign pc_write   = w_out.pcWrite;
   assign pc_src     = w_out.pcSrc;
   assign reg_write  = w_out.regWrite;
   assign mem_to_reg = w_out.memToReg;
   assign alu_src_a  = w_out.aluSrcA;
   assign alu_src_b  = w_out.aluSrcB;
   assign alu_ctrl   = w_out.aluCtrl;
   assign retire     = w_out.retire;
   assign illegal    = w_out.illegal;
   assign state      = r_state;

endmodule
